// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared widths, types and constants for the MIPS register file
package mips_pkg;

   localparam int DATA_W  = 32;
   localparam int ADDR_W  = 5;
   localparam int DEPTH   = 2 ** ADDR_W;
   localparam int WCNT_W  = 16;

   typedef logic [DATA_W-1:0] word_t;
   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [WCNT_W-1:0] wcnt_t;

   localparam reg_addr_t ZERO_REG = '0;
   localparam wcnt_t     WCNT_MAX = '1;

endpackage

// File: rtl/banco_registradores_if.sv
// rtl/banco_registradores_if.sv - datapath-side read/write bus of the register file
interface banco_registradores_if;
   import mips_pkg::*;

   logic      we;
   reg_addr_t wa;
   word_t     wd;
   reg_addr_t ra1;
   reg_addr_t ra2;
   word_t     rd1;
   word_t     rd2;
   logic      rv1;
   logic      rv2;
   wcnt_t     wr_count;

   modport master (
      output we, wa, wd, ra1, ra2,
      input  rd1, rd2, rv1, rv2, wr_count
   );

   modport slave (
      input  we, wa, wd, ra1, ra2,
      output rd1, rd2, rv1, rv2, wr_count
   );

endinterface

// File: rtl/banco_decodificador_escrita.sv
// rtl/banco_decodificador_escrita.sv - write-address decoder, one-hot enable with r0 never selected
module banco_decodificador_escrita
   import mips_pkg::*;
(
   input  logic             we,
   input  reg_addr_t        wa,
   output logic [DEPTH-1:0] en
);

   // The zero-register rule lives only here: r0 can never be enabled.
   always_comb begin
      en = '0;
      if (we && (wa != ZERO_REG)) begin
         en[wa] = 1'b1;
      end
      en[0] = 1'b0;
   end

endmodule

// File: rtl/banco_registradores.sv
// rtl/banco_registradores.sv - 32x32 MIPS register file, 2 async read ports, 1 sync write port
// Optional write-to-read forwarding: BANCO_BYPASS_EN
module banco_registradores
   import mips_pkg::*;
(
   input  logic                   ck,
   input  logic                   reset_register,
   banco_registradores_if.slave   bus
);

   word_t            mem [DEPTH];
   logic [DEPTH-1:0] written;
   logic [DEPTH-1:0] wen;
   wcnt_t            wr_count_q;

   banco_decodificador_escrita u_dec (
      .we (bus.we),
      .wa (bus.wa),
      .en (wen)
   );

   always_ff @(posedge ck or negedge reset_register) begin
      if (!reset_register) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         written    <= '0;
         wr_count_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wen[i]) begin
               mem[i]     <= bus.wd;
               written[i] <= 1'b1;
            end
         end
         if ((|wen) && (wr_count_q != WCNT_MAX)) begin
            wr_count_q <= wr_count_q + wcnt_t'(1);
         end
      end
   end

   assign bus.wr_count = wr_count_q;

   // r0 is never written, so its storage stays 0; its valid flag is forced high.
   always_comb begin
      bus.rd1 = mem[bus.ra1];
      bus.rv1 = written[bus.ra1] | (bus.ra1 == ZERO_REG);
      bus.rd2 = mem[bus.ra2];
      bus.rv2 = written[bus.ra2] | (bus.ra2 == ZERO_REG);
`ifdef BANCO_BYPASS_EN
      if (reset_register && wen[bus.ra1]) begin
         bus.rd1 = bus.wd;
         bus.rv1 = 1'b1;
      end
      if (reset_register && wen[bus.ra2]) begin
         bus.rd2 = bus.wd;
         bus.rv2 = 1'b1;
      end
`endif
   end

endmodule

// File: tb/tb_banco_registradores.sv
// tb/tb_banco_registradores.sv - scoreboard bench for banco_registradores
module tb_banco_registradores;
   import mips_pkg::*;

   logic ck;
   logic reset_register;

   banco_registradores_if bus ();

   banco_registradores dut (
      .ck             (ck),
      .reset_register (reset_register),
      .bus            (bus)
   );

   initial ck = 1'b0;
   always #5 ck = ~ck;

   typedef struct {
      string       tag;
      int          sel;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb [$];
   int          n_checks;
   int          n_fail;
   logic [31:0] m_mem [32];
   logic        m_wr  [32];
   logic [15:0] m_cnt;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sample(input int sel);
      case (sel)
         0:       return bus.rd1;
         1:       return bus.rd2;
         2:       return {31'd0, bus.rv1};
         3:       return {31'd0, bus.rv2};
         default: return {16'd0, bus.wr_count};
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [31:0] exp);
      exp_t e;
      e.tag = tag; e.sel = sel; e.exp = exp;
      sb.push_back(e);
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check_eq(e.tag, sample(e.sel), e.exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         m_mem[i] = '0;
         m_wr[i]  = 1'b0;
      end
      m_cnt = '0;
   endtask

   task automatic model_write(input int a, input logic [31:0] d);
      if (a != 0) begin
         m_mem[a] = d;
         m_wr[a]  = 1'b1;
         if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end
   endtask

   // Expected values come from the model; ports sampled 1 time unit later.
   task automatic read_check(input string t, input int a1, input int a2);
      bus.ra1 = reg_addr_t'(a1);
      bus.ra2 = reg_addr_t'(a2);
      push($sformatf("%s.rd1", t), 0, m_mem[a1]);
      push($sformatf("%s.rd2", t), 1, m_mem[a2]);
      push($sformatf("%s.rv1", t), 2, {31'd0, m_wr[a1] | (a1 == 0)});
      push($sformatf("%s.rv2", t), 3, {31'd0, m_wr[a2] | (a2 == 0)});
      push($sformatf("%s.cnt", t), 4, {16'd0, m_cnt});
      #1;
      drain();
   endtask

   task automatic do_write(input int a, input logic [31:0] d);
      @(negedge ck);
      bus.we = 1'b1;
      bus.wa = reg_addr_t'(a);
      bus.wd = d;
      @(negedge ck);
      bus.we = 1'b0;
      model_write(a, d);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      model_reset();
      reset_register = 1'b0;
      bus.we  = 1'b0;
      bus.wa  = '0;
      bus.wd  = '0;
      bus.ra1 = '0;
      bus.ra2 = '0;

      #12;
      read_check("rst_init", 5, 0);

      @(negedge ck);
      reset_register = 1'b1;
      do_write(5, 32'hDEADBEEF);
      read_check("w5", 5, 5);

      // Reset mid-cycle with a pending write: reset wins and clears immediately.
      @(negedge ck);
      bus.we  = 1'b1;
      bus.wa  = 5'd5;
      bus.wd  = 32'h1234_5678;
      #2;
      reset_register = 1'b0;
      model_reset();
      read_check("rst_mid", 5, 0);
      @(posedge ck);
      #1;
      read_check("rst_hold", 5, 5);
      @(negedge ck);
      bus.we = 1'b0;
      reset_register = 1'b1;

      for (int n = 1; n < 32; n++) begin
         do_write(n, 32'h1000_0000 + n);
      end
      for (int n = 1; n < 32; n++) begin
         read_check($sformatf("rb%0d", n), n, n);
      end

      do_write(0, 32'hFFFF_FFFF);
      read_check("r0", 0, 0);

      do_write(7, 32'h11);
      @(negedge ck);
      bus.we  = 1'b1;
      bus.wa  = 5'd7;
      bus.wd  = 32'h22;
      bus.ra1 = 5'd7;
      bus.ra2 = 5'd6;
`ifdef BANCO_BYPASS_EN
      push("same_pre.rd1", 0, 32'h22);
`else
      push("same_pre.rd1", 0, 32'h11);
`endif
      push("same_pre.rv1", 2, 32'd1);
      push("same_pre.rd2", 1, m_mem[6]);
      #1;
      drain();
      @(negedge ck);
      bus.we = 1'b0;
      model_write(7, 32'h22);
      read_check("same_post", 7, 7);

      read_check("dual33", 3, 3);
      read_check("dual34", 3, 4);
      @(negedge ck);
      bus.we  = 1'b1;
      bus.wa  = 5'd4;
      bus.wd  = 32'hCAFE_0004;
      bus.ra1 = 5'd3;
      @(negedge ck);
      bus.we = 1'b0;
      model_write(4, 32'hCAFE_0004);
      read_check("dual_wr4", 3, 4);

      // Saturation: far more writes than the counter can hold.
      @(negedge ck);
      bus.we = 1'b1;
      bus.wa = 5'd2;
      for (int i = 0; i < 65537; i++) begin
         bus.wd = 32'hA000_0000 + i;
         @(negedge ck);
         model_write(2, 32'hA000_0000 + i);
      end
      bus.we = 1'b0;
      read_check("sat", 2, 4);
      check_eq("sat_const", {16'd0, bus.wr_count}, 32'h0000_FFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
